// File: rtl/mem_responder.sv
// Multi-cycle single-ported memory responder with programmable wait states and a
// four-phase ready handshake; all outputs come straight from registers.
module mem_responder #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_ready_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_err_o,
  output logic              busy_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              req_s;
  logic              in_range_s;
  logic              commit_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  idx_s;

  assign req_s      = mem_read_i | mem_write_i;
  assign in_range_s = ({1'b0, addr_q} < DEPTH_X);
  assign idx_s      = addr_q[IDX_W-1:0];
  // The counter is loaded with WAIT_CYCLES and WAIT always spans one extra edge, so a
  // request sampled at edge N is answered after edge N+WAIT_CYCLES+1 (also for zero waits).
  assign commit_s   = (state_q == ST_WAIT) && (cnt_q == '0);
  assign mem_we_s   = commit_s & wr_q & ~rd_q & in_range_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          rd_d    = mem_read_i;
          wr_d    = mem_write_i;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          // Conflict leaves rdata untouched; out-of-range clears it.
          if (rd_q && wr_q) begin
            err_d = 1'b1;
          end else if (!in_range_s) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            err_d = 1'b0;
            if (rd_q) begin
              rdata_d = mem_q[idx_s];
            end else begin
              rdata_d = rdata_q;
            end
          end
        end
      end
      ST_RESP: begin
        if (!req_s) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is deliberately not reset; reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= wdata_q;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign mem_err_o   = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) share one request bus and
// are checked against a reference memory model for data, error, latency and handshake.
module tb_mem_responder;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [12:0] req_addr = 13'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic [1:0]  rdy;
  logic [1:0]  err;
  logic [1:0]  bsy;
  logic [7:0]  rdata [2];

  int          checks = 0;
  int          errors = 0;
  exp_t        sbq0 [$];
  exp_t        sbq1 [$];
  logic [7:0]  mdl [int];
  logic [7:0]  last_rdata = 8'd0;
  int          wait_of [2] = '{2, 0};

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(13), .DATA_W(8), .DEPTH(4096), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .mem_read_i(req_rd), .mem_write_i(req_wr),
    .mem_addr_i(req_addr), .mem_wdata_i(req_wdata),
    .mem_ready_o(rdy[0]), .mem_rdata_o(rdata[0]), .mem_err_o(err[0]), .busy_o(bsy[0])
  );

  mem_responder #(.ADDR_W(13), .DATA_W(8), .DEPTH(4096), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .mem_read_i(req_rd), .mem_write_i(req_wr),
    .mem_addr_i(req_addr), .mem_wdata_i(req_wdata),
    .mem_ready_o(rdy[1]), .mem_rdata_o(rdata[1]), .mem_err_o(err[1]), .busy_o(bsy[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("%s_ready%0d", tag, k), {31'd0, rdy[k]}, 32'd0);
      check_val($sformatf("%s_busy%0d", tag, k), {31'd0, bsy[k]}, 32'd0);
      check_val($sformatf("%s_err%0d", tag, k), {31'd0, err[k]}, 32'd0);
      check_val($sformatf("%s_rdata%0d", tag, k), {24'd0, rdata[k]}, 32'd0);
    end
  endtask

  // Drive one request held for 'hold' edges (capture edge = 1) and score both responders.
  task automatic run_xact(input logic rd, input logic wr, input logic [12:0] a,
                          input logic [7:0] d, input int hold);
    exp_t ex;
    exp_t got_ex;
    int   rise [2];
    int   high [2];
    bit   done [2];
    int   eh;
    if (rd && wr) begin
      ex.err = 1'b1; ex.rdata = last_rdata;
    end else if (a >= 13'd4096) begin
      ex.err = 1'b1; ex.rdata = 8'd0;
    end else if (rd) begin
      ex.err = 1'b0; ex.rdata = mdl.exists(int'(a)) ? mdl[int'(a)] : 8'hxx;
    end else begin
      ex.err = 1'b0; ex.rdata = last_rdata; mdl[int'(a)] = d;
    end
    last_rdata = ex.rdata;
    sbq0.push_back(ex);
    sbq1.push_back(ex);
    rise = '{0, 0}; high = '{0, 0}; done = '{1'b0, 1'b0};
    req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
    for (int e = 1; e <= 40 && !(done[0] && done[1]); e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (!done[k]) begin
          if (rdy[k]) begin
            if (rise[k] == 0) begin
              rise[k] = e;
              check_val($sformatf("latency%0d", k), e, wait_of[k] + 2);
              if ((k == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                check_val($sformatf("sb_empty%0d", k), 32'd1, 32'd0);
                got_ex = ex;
              end else begin
                got_ex = (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
              end
              check_val($sformatf("rdata%0d@%0h", k, a), {24'd0, rdata[k]}, {24'd0, got_ex.rdata});
              check_val($sformatf("err%0d@%0h", k, a), {31'd0, err[k]}, {31'd0, got_ex.err});
              check_val($sformatf("busy_resp%0d", k), {31'd0, bsy[k]}, 32'd1);
            end
            high[k]++;
          end else if (rise[k] != 0) begin
            done[k] = 1'b1;
            eh = (hold >= rise[k]) ? hold + 1 - rise[k] : 1;
            check_val($sformatf("ready_width%0d", k), high[k], eh);
            check_val($sformatf("busy_idle%0d", k), {31'd0, bsy[k]}, 32'd0);
            check_val($sformatf("err_idle%0d", k), {31'd0, err[k]}, 32'd0);
            check_val($sformatf("rdata_hold%0d", k), {24'd0, rdata[k]}, {24'd0, ex.rdata});
          end else begin
            check_val($sformatf("busy_wait%0d", k), {31'd0, bsy[k]}, 32'd1);
          end
        end
      end
      if (e == hold) begin
        req_rd = 1'b0; req_wr = 1'b0;
      end
    end
    req_rd = 1'b0; req_wr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (!done[k]) check_val($sformatf("timeout%0d", k), 32'd0, 32'd1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_xact(1'b0, 1'b1, 13'h010, 8'hA5, 4);
    run_xact(1'b1, 1'b0, 13'h010, 8'h00, 4);
    run_xact(1'b0, 1'b1, 13'h000, 8'h5A, 4);
    run_xact(1'b0, 1'b1, 13'h1000, 8'h3C, 4);
    run_xact(1'b1, 1'b0, 13'h000, 8'h00, 4);
    run_xact(1'b0, 1'b1, 13'h020, 8'h11, 4);
    run_xact(1'b1, 1'b1, 13'h020, 8'hFF, 4);
    run_xact(1'b1, 1'b0, 13'h020, 8'h00, 4);
    run_xact(1'b1, 1'b0, 13'h010, 8'h00, 1);
    run_xact(1'b1, 1'b0, 13'h000, 8'h00, 9);
    run_xact(1'b0, 1'b1, 13'h0FFF, 8'hC3, 4);
    run_xact(1'b1, 1'b0, 13'h0FFF, 8'h00, 4);
    run_xact(1'b1, 1'b0, 13'h1FFF, 8'h00, 4);
    for (int i = 0; i < 4; i++) begin
      run_xact(1'b0, 1'b1, 13'h100 + 13'(i), 8'($urandom_range(0, 255)), 4);
    end
    for (int i = 3; i >= 0; i--) begin
      run_xact(1'b1, 1'b0, 13'h100 + 13'(i), 8'h00, 5);
    end

    // Reset asserted while both responders hold a captured, uncommitted write.
    run_xact(1'b0, 1'b1, 13'h030, 8'h12, 4);
    req_wr = 1'b1; req_addr = 13'h030; req_wdata = 8'h77;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("busy_pre_rst%0d", k), {31'd0, bsy[k]}, 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    req_wr = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("rst_held");
    @(negedge clk);
    rst = 1'b0;
    last_rdata = 8'd0;
    run_xact(1'b1, 1'b0, 13'h030, 8'h00, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
